pc_redirect_controller: RTL and testbench
=========================================

// Module: pc_redirect_controller
// PURPOSE
//  Source side of the dual-selector next-PC mux. Samples taken-branch (EX) and jump (ID) events
//  and drives the two mux select lines (Selector1 = branch, Selector2 = jump) plus the redirect target.
//  Generates IF/ID and ID/EX flush pulses and holds a redirect pending while the pipeline is stalled.
//  Sits between the control/ALU outputs and the PC-source mux of the MIPS pipeline.
// PARAMETERS
//  NBits        32  width of PC / target addresses
//  FLUSH_CYCLES 1   cycles Flush_IFID stays high per redirect (1..7)
//  CNT_W        16  width of the redirect event counter
// PORTS
//  clk            in   1         rising-edge clock
//  reset          in   1         asynchronous, active-low reset
//  Branch_EX      in   1         branch instruction in EX
//  BranchCond_EX  in   1         branch condition true (taken when Branch_EX & BranchCond_EX)
//  BranchTarget   in   NBits     branch target address from EX
//  Jump_ID        in   1         jump decoded in ID
//  JumpTarget     in   NBits     jump target address from ID
//  Stall          in   1         pipeline stall from the hazard unit (PC/IF/ID frozen)
//  Redirect_Br    out  1         mux Selector1: branch redirect this cycle
//  Redirect_Jmp   out  1         mux Selector2: jump redirect this cycle
//  RedirectTarget out  NBits     address for the mux Data1 input
//  Flush_IFID     out  1         squash IF/ID register
//  Flush_IDEX     out  1         squash ID/EX register (branch redirects only)
//  Busy           out  1         redirect pending or flush in progress
//  RedirectCount  out  CNT_W     redirects issued since reset
// BEHAVIOUR
//  - All outputs registered. Reset (reset==0, async): every output = 0, state = IDLE, target = 0.
//  - Event = taken branch (Branch_EX & BranchCond_EX) or Jump_ID. Same-cycle collision: branch wins,
//    jump dropped (it is on the wrong path).
//  - States: IDLE, PENDING, FLUSH.
//  - IDLE, event, Stall=0 at edge N -> FLUSH. Cycle N+1:
//    - Redirect_Br or Redirect_Jmp = 1 for exactly one cycle; never both.
//    - RedirectTarget = matching target.
//    - Flush_IFID = 1.
//    - Flush_IDEX = 1 for branch only, one cycle.
//    - RedirectCount += 1, wraps at 2^CNT_W-1 -> 0.
//  - IDLE, event, Stall=1 -> PENDING. Type and target latched, no selector asserted, Busy = 1.
//  - PENDING: holds while Stall=1. First edge with Stall=0 issues the redirect exactly as above (one
//    cycle later), then -> FLUSH. A taken branch arriving in PENDING overrides a pending jump (branch
//    type and target replace it); every other new event is ignored.
//  - FLUSH: Flush_IFID stays high for FLUSH_CYCLES cycles counted from the issue cycle.
//    - All events are ignored (squashed path).
//    - Stall during FLUSH does not extend it.
//    - Returns to IDLE after the last flush cycle. An event in that IDLE cycle is accepted normally.
//  - Busy = 1 in PENDING and FLUSH, else 0.
//  - RedirectTarget holds its last value when no selector is asserted.
//  - Reset asserted mid-PENDING/FLUSH: pending redirect discarded, no selector pulse after release.
// TESTING
//  1. Taken branch Target=0x0040_0020, Stall=0 -> next cycle Redirect_Br=1, Target=0x0040_0020,
//     Flush_IFID=Flush_IDEX=1, Count=1.
//  2. Jump_ID Target=0x0040_0100 -> one-cycle Redirect_Jmp=1, Flush_IFID=1, Flush_IDEX=0.
//  3. Branch and jump in the same cycle -> only Redirect_Br, branch target; Count +1.
//  4. Jump with Stall=1 for 3 cycles, taken branch in cycle 2 -> no selector during the stall; after
//     Stall drops Redirect_Br with the branch target.
//  5. FLUSH_CYCLES=3: jump, then jump events in the 2 flush cycles -> single redirect, Flush_IFID
//     high 3 cycles, Count=1.
//  6. Reset pulsed in PENDING -> outputs 0 immediately; no redirect after release. CNT_W=4, 16
//     redirects -> Count wraps to 0.

Source files
------------

// File: rtl/pc_redirect_controller_if.sv
// Redirect bundle between the EX/ID control sources and the next-PC mux.
// master = event sources (control/ALU side), slave = redirect controller.
interface pc_redirect_controller_if #(
   parameter int unsigned NBits = 32,
   parameter int unsigned CNT_W = 16
);
   logic             Branch_EX;
   logic             BranchCond_EX;
   logic [NBits-1:0] BranchTarget;
   logic             Jump_ID;
   logic [NBits-1:0] JumpTarget;
   logic             Stall;
   logic             Redirect_Br;
   logic             Redirect_Jmp;
   logic [NBits-1:0] RedirectTarget;
   logic             Flush_IFID;
   logic             Flush_IDEX;
   logic             Busy;
   logic [CNT_W-1:0] RedirectCount;

   modport master (
      output Branch_EX, BranchCond_EX, BranchTarget, Jump_ID, JumpTarget, Stall,
      input  Redirect_Br, Redirect_Jmp, RedirectTarget, Flush_IFID, Flush_IDEX, Busy,
             RedirectCount
   );

   modport slave (
      input  Branch_EX, BranchCond_EX, BranchTarget, Jump_ID, JumpTarget, Stall,
      output Redirect_Br, Redirect_Jmp, RedirectTarget, Flush_IFID, Flush_IDEX, Busy,
             RedirectCount
   );
endinterface

// File: rtl/pc_redirect_controller.sv
// Drives the dual-selector next-PC mux: branch (Selector1) / jump (Selector2) redirects,
// IF/ID and ID/EX flush pulses, and holds a redirect while the pipeline is stalled.
module pc_redirect_controller #(
   parameter int unsigned NBits        = 32,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input logic                     clk,
   input logic                     reset,
   pc_redirect_controller_if.slave bus
);
   typedef enum logic [1:0] {StIdle, StPending, StFlush} state_e;

   localparam logic [2:0] FlushLast = 3'(FLUSH_CYCLES - 1);

   state_e           state_q, state_d;
   logic             pend_br_q, pend_br_d;
   logic [NBits-1:0] pend_tgt_q, pend_tgt_d;
   logic [2:0]       flush_cnt_q, flush_cnt_d;
   logic             redir_br_q, redir_br_d;
   logic             redir_jmp_q, redir_jmp_d;
   logic [NBits-1:0] tgt_q, tgt_d;
   logic             flush_ifid_q, flush_ifid_d;
   logic             flush_idex_q, flush_idex_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             taken;
   logic             cand_br;
   logic [NBits-1:0] cand_tgt;
   logic             do_issue;

   assign taken = bus.Branch_EX & bus.BranchCond_EX;

   // Next-state: accept/merge events, issue when unstalled, time out the flush window.
   always_comb begin
      state_d      = state_q;
      pend_br_d    = pend_br_q;
      pend_tgt_d   = pend_tgt_q;
      flush_cnt_d  = flush_cnt_q;
      redir_br_d   = 1'b0;
      redir_jmp_d  = 1'b0;
      tgt_d        = tgt_q;
      flush_idex_d = 1'b0;
      cnt_d        = cnt_q;
      cand_br      = pend_br_q;
      cand_tgt     = pend_tgt_q;
      do_issue     = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Branch wins a same-cycle collision: the jump is on the wrong path.
            if (taken || bus.Jump_ID) begin
               cand_br  = taken;
               cand_tgt = taken ? bus.BranchTarget : bus.JumpTarget;
               if (bus.Stall) begin
                  state_d    = StPending;
                  pend_br_d  = cand_br;
                  pend_tgt_d = cand_tgt;
               end else begin
                  do_issue = 1'b1;
               end
            end
         end
         StPending: begin
            // An older taken branch overrides a pending jump; anything else is ignored.
            if (taken && !pend_br_q) begin
               cand_br  = 1'b1;
               cand_tgt = bus.BranchTarget;
            end
            pend_br_d  = cand_br;
            pend_tgt_d = cand_tgt;
            if (!bus.Stall) do_issue = 1'b1;
         end
         StFlush: begin
            if (flush_cnt_q == 3'd0) state_d = StIdle;
            else                     flush_cnt_d = flush_cnt_q - 3'd1;
         end
         default: state_d = StIdle;
      endcase

      if (do_issue) begin
         state_d      = StFlush;
         flush_cnt_d  = FlushLast;
         redir_br_d   = cand_br;
         redir_jmp_d  = !cand_br;
         tgt_d        = cand_tgt;
         flush_idex_d = cand_br;
         cnt_d        = cnt_q + CNT_W'(1);
      end

      flush_ifid_d = (state_d == StFlush);
      busy_d       = (state_d != StIdle);
   end

   // State and registered outputs; async reset discards any pending redirect.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         pend_br_q    <= 1'b0;
         pend_tgt_q   <= '0;
         flush_cnt_q  <= '0;
         redir_br_q   <= 1'b0;
         redir_jmp_q  <= 1'b0;
         tgt_q        <= '0;
         flush_ifid_q <= 1'b0;
         flush_idex_q <= 1'b0;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         pend_br_q    <= pend_br_d;
         pend_tgt_q   <= pend_tgt_d;
         flush_cnt_q  <= flush_cnt_d;
         redir_br_q   <= redir_br_d;
         redir_jmp_q  <= redir_jmp_d;
         tgt_q        <= tgt_d;
         flush_ifid_q <= flush_ifid_d;
         flush_idex_q <= flush_idex_d;
         busy_q       <= busy_d;
         cnt_q        <= cnt_d;
      end
   end

   assign bus.Redirect_Br    = redir_br_q;
   assign bus.Redirect_Jmp   = redir_jmp_q;
   assign bus.RedirectTarget = tgt_q;
   assign bus.Flush_IFID     = flush_ifid_q;
   assign bus.Flush_IDEX     = flush_idex_q;
   assign bus.Busy           = busy_q;
   assign bus.RedirectCount  = cnt_q;
endmodule

// File: tb/tb_pc_redirect_controller.sv
// Bench for pc_redirect_controller: two instances (default, and FLUSH_CYCLES=3/CNT_W=4)
// driven with identical stimulus and compared each cycle against an event-level model.
module tb_pc_redirect_controller;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   pc_redirect_controller_if #(.NBits(32), .CNT_W(16)) if0 ();
   pc_redirect_controller_if #(.NBits(32), .CNT_W(4))  if1 ();

   pc_redirect_controller #(.NBits(32), .FLUSH_CYCLES(1), .CNT_W(16)) dut0 (
      .clk(clk), .reset(reset), .bus(if0.slave));
   pc_redirect_controller #(.NBits(32), .FLUSH_CYCLES(3), .CNT_W(4)) dut1 (
      .clk(clk), .reset(reset), .bus(if1.slave));

   logic        in_br = 0, in_cond = 0, in_j = 0, in_stall = 0;
   logic [31:0] in_bt = 0, in_jt = 0;

   assign if0.Branch_EX = in_br;  assign if0.BranchCond_EX = in_cond;
   assign if0.BranchTarget = in_bt; assign if0.Jump_ID = in_j;
   assign if0.JumpTarget = in_jt; assign if0.Stall = in_stall;
   assign if1.Branch_EX = in_br;  assign if1.BranchCond_EX = in_cond;
   assign if1.BranchTarget = in_bt; assign if1.Jump_ID = in_j;
   assign if1.JumpTarget = in_jt; assign if1.Stall = in_stall;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: a pending redirect record plus a count of flush cycles left.
   int          fc[2] = '{1, 3};
   int          cw[2] = '{16, 4};
   bit          m_pend[2], m_pbr[2];
   logic [31:0] m_ptgt[2];
   int          m_fl[2];
   int          m_cnt[2];
   bit          e_br[2], e_jmp[2], e_idex[2];
   logic [31:0] e_tgt[2];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_pend[i] = 0; m_pbr[i] = 0; m_ptgt[i] = 0; m_fl[i] = 0; m_cnt[i] = 0;
         e_br[i] = 0; e_jmp[i] = 0; e_idex[i] = 0; e_tgt[i] = 0;
      end
   endfunction

   function automatic void model_step(int i);
      bit tk = in_br && in_cond;
      e_br[i] = 0; e_jmp[i] = 0; e_idex[i] = 0;
      if (m_fl[i] > 0) begin
         m_fl[i]--;
      end else begin
         if (m_pend[i]) begin
            if (tk && !m_pbr[i]) begin m_pbr[i] = 1; m_ptgt[i] = in_bt; end
         end else if (tk || in_j) begin
            m_pend[i] = 1; m_pbr[i] = tk; m_ptgt[i] = tk ? in_bt : in_jt;
         end
         if (m_pend[i] && !in_stall) begin
            e_br[i] = m_pbr[i]; e_jmp[i] = !m_pbr[i]; e_idex[i] = m_pbr[i];
            e_tgt[i] = m_ptgt[i];
            m_cnt[i] = (m_cnt[i] + 1) % (1 << cw[i]);
            m_fl[i] = fc[i];
            m_pend[i] = 0;
         end
      end
   endfunction

   task automatic check_all(int i);
      logic br, jmp, fi, fx, bsy;
      logic [31:0] tg;
      logic [15:0] cnt;
      if (i == 0) begin
         br = if0.Redirect_Br; jmp = if0.Redirect_Jmp; tg = if0.RedirectTarget;
         fi = if0.Flush_IFID; fx = if0.Flush_IDEX; bsy = if0.Busy; cnt = if0.RedirectCount;
      end else begin
         br = if1.Redirect_Br; jmp = if1.Redirect_Jmp; tg = if1.RedirectTarget;
         fi = if1.Flush_IFID; fx = if1.Flush_IDEX; bsy = if1.Busy;
         cnt = {12'd0, if1.RedirectCount};
      end
      check_eq($sformatf("redir_br%0d", i), 64'(br), 64'(e_br[i]));
      check_eq($sformatf("redir_jmp%0d", i), 64'(jmp), 64'(e_jmp[i]));
      check_eq($sformatf("target%0d", i), 64'(tg), 64'(e_tgt[i]));
      check_eq($sformatf("flush_ifid%0d", i), 64'(fi), 64'(m_fl[i] > 0));
      check_eq($sformatf("flush_idex%0d", i), 64'(fx), 64'(e_idex[i]));
      check_eq($sformatf("busy%0d", i), 64'(bsy), 64'(m_pend[i] || m_fl[i] > 0));
      check_eq($sformatf("count%0d", i), 64'(cnt), 64'(m_cnt[i]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0);
      model_step(1);
      #1;
      check_all(0);
      check_all(1);
   endtask

   task automatic drive(bit br, bit cond, logic [31:0] bt, bit j, logic [31:0] jt, bit st);
      in_br = br; in_cond = cond; in_bt = bt; in_j = j; in_jt = jt; in_stall = st;
   endtask

   task automatic idle(int n);
      drive(0, 0, 0, 0, 0, 0);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic pulse_reset();
      #2 reset = 1'b0;
      #1;
      check_eq("rst_br0", 64'(if0.Redirect_Br), 0);
      check_eq("rst_busy0", 64'(if0.Busy), 0);
      check_eq("rst_busy1", 64'(if1.Busy), 0);
      check_eq("rst_flush1", 64'(if1.Flush_IFID), 0);
      check_eq("rst_tgt0", 64'(if0.RedirectTarget), 0);
      check_eq("rst_cnt0", 64'(if0.RedirectCount), 0);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      model_reset();
      #1;
      check_eq("por_busy0", 64'(if0.Busy), 0);
      check_eq("por_cnt0", 64'(if0.RedirectCount), 0);
      @(negedge clk);
      reset = 1'b1;
      idle(2);

      // 1: taken branch, no stall
      drive(1, 1, 32'h0040_0020, 0, 0, 0);
      tick();
      check_eq("t1_br", 64'(if0.Redirect_Br), 1);
      check_eq("t1_tgt", 64'(if0.RedirectTarget), 64'h0040_0020);
      check_eq("t1_idex", 64'(if0.Flush_IDEX), 1);
      check_eq("t1_cnt", 64'(if0.RedirectCount), 1);
      idle(4);

      // 2: jump
      drive(0, 0, 0, 1, 32'h0040_0100, 0);
      tick();
      check_eq("t2_jmp", 64'(if0.Redirect_Jmp), 1);
      check_eq("t2_idex", 64'(if0.Flush_IDEX), 0);
      idle(4);

      // 3: branch/jump collision
      drive(1, 1, 32'h0000_1230, 1, 32'h0000_4560, 0);
      tick();
      check_eq("t3_tgt", 64'(if0.RedirectTarget), 64'h0000_1230);
      idle(4);

      // 4: jump under stall, branch override in second stalled cycle
      drive(0, 0, 0, 1, 32'h0000_8000, 1);
      tick();
      drive(1, 1, 32'h0000_9000, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      tick();
      check_eq("t4_br", 64'(if0.Redirect_Br), 1);
      check_eq("t4_tgt", 64'(if0.RedirectTarget), 64'h0000_9000);
      idle(4);

      // 5: jumps inside the 3-cycle flush window are squashed (instance 1)
      pulse_reset();
      drive(0, 0, 0, 1, 32'h0000_0a00, 0);
      tick();
      drive(0, 0, 0, 1, 32'h0000_0b00, 0);
      tick();
      tick();
      check_eq("t5_flush", 64'(if1.Flush_IFID), 1);
      idle(1);
      check_eq("t5_cnt", 64'(if1.RedirectCount), 1);
      idle(3);

      // 6: reset while pending, then counter wrap on instance 1
      drive(0, 0, 0, 1, 32'h0000_0c00, 1);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      pulse_reset();
      idle(3);
      for (int n = 0; n < 16; n++) begin
         drive(0, 0, 0, 1, 32'h0000_1000 + 32'(n), 0);
         tick();
         idle(4);
      end
      check_eq("t6_wrap", 64'(if1.RedirectCount), 0);

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         drive(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom(),
               1'($urandom_range(0, 3) == 0), $urandom(), 1'($urandom_range(0, 2) == 0));
         tick();
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
